serial_comp_32: RTL and testbench
=================================

Name: serial_comp_32

Overview:
- Multi-cycle, bit-serial counterpart of the team's combinational 32-bit comparator.
- Accepts two operands on a start strobe and scans them MSB-first, one bit per clock.
- Produces the same unsigned-less (ul) and signed-less (sl) flags, plus equality and a done pulse.
- Used by lab datapaths that trade comparator area for latency, and as a cross-check against the combinational comparator.

Parameters:
WIDTH, 32, operand width in bits (minimum 2)
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when results become valid
ul  output  1  1 when a < b, unsigned compare
sl  output  1  1 when a < b, two's-complement signed compare
eq  output  1  1 when a == b

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset:
  - state=IDLE; busy=0, done=0, ul=0, sl=0, eq=0.
  - Shift registers, counter and internal flags cleared.
  - Reset asserted mid-RUN abandons the operation immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge loads a and b into shift regs, sets cnt=WIDTH-1, clears decided/lt/msb_diff, moves to RUN.
  - Result outputs keep their previous values.
- RUN (busy=1):
  - Each edge compares the current MSBs abit and bbit, then shifts both registers left by 1 and decrements cnt.
  - If decided=0 and abit!=bbit: set decided=1, lt=bbit (i.e. abit=0 and bbit=1).
  - If that first difference occurs at cnt==WIDTH-1, also set msb_diff=1.
  - Once decided=1, later bits are ignored.
  - At cnt==0 the edge processes the last bit and moves to DONE.
  - start is ignored throughout RUN; operand inputs are don't-care after capture.
- Result computation, registered on the edge leaving RUN:
  - ul = lt
  - sl = lt XOR msb_diff (if the sign bits differ, the operand with MSB=1 is the lesser)
  - eq = ~decided
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation, zero dead cycles); otherwise next state is IDLE.
- Latency:
  - Accepted start edge = E0; the bits are processed on edges E1..E_WIDTH.
  - done is high in the cycle following E_WIDTH.
  - ul/sl/eq become valid in that same cycle and hold until the next operation completes.
- Invariants:
  - eq=1 implies ul=0 and sl=0.
  - busy and done are never high together.
  - No combinational path from inputs to outputs; all outputs are registered.
- Simultaneous events: rst dominates start; start while busy has no effect and is not queued.

Test Plan:
- Basic unsigned/signed less: a=5, b=7, start pulse -> done high in the cycle after E32; ul=1, sl=1, eq=0; busy high for exactly 32 cycles.
- Sign-bit difference, case 1: a=0xFFFFFFFF, b=0x00000001 -> ul=0, sl=1, eq=0.
- Sign-bit difference, case 2: a=0x7FFFFFFF, b=0x80000000 -> ul=1, sl=0, eq=0.
- Equality and LSB-only difference:
  - a=b=0x12345678 -> eq=1, ul=0, sl=0.
  - Then a=0x12345678, b=0x12345679 -> ul=1, sl=1, eq=0.
- Handshake:
  - start reasserted with new operands during RUN -> ignored; the result matches the first operands and exactly one done pulse occurs.
  - start in the DONE cycle with a=3, b=2 -> second done exactly 33 cycles after the first, with ul=0, sl=0.
- Reset mid-operation: rst pulsed at E10 of a run -> all outputs 0, no done pulse. A fresh start with a=0x80000000, b=0 then completes with ul=0, sl=1.

Source files
------------

// File: rtl/serial_comp_32.sv
// -----------------------------------------------------------------------------
// serial_comp_32
//
// Bit-serial magnitude comparator. Two operands are captured on an accepted
// start strobe and scanned MSB-first, one bit per clock. The first differing
// bit decides the unsigned ordering; if that difference sits in the sign bit
// the signed ordering is the opposite of the unsigned one.
//
// Ports:
//   clk    in   1      system clock, rising-edge active
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; honoured only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on the accepted start edge
//   busy   out  1      high while bits are being scanned (RUN)
//   done   out  1      one-cycle pulse when ul/sl/eq become valid
//   ul     out  1      a < b, unsigned
//   sl     out  1      a < b, two's-complement signed
//   eq     out  1      a == b
//
// Timing: accepted start on edge E0, bits processed on E1..E_WIDTH, done high
// in the cycle after E_WIDTH. A start seen during the DONE cycle is accepted
// like one in IDLE, so operations can run back-to-back with no dead cycle.
// Results hold until the next operation completes.
//
// Parameter constraints: WIDTH >= 2 and 2**CNT_W > WIDTH.
// -----------------------------------------------------------------------------
module serial_comp_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             ul,
    output logic             sl,
    output logic             eq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] a_sr_q,     a_sr_d;
    logic [WIDTH-1:0] b_sr_q,     b_sr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             decided_q,  decided_d;
    logic             lt_q,       lt_d;
    logic             msb_diff_q, msb_diff_d;
    logic             ul_q,       ul_d;
    logic             sl_q,       sl_d;
    logic             eq_q,       eq_d;

    logic abit;
    logic bbit;

    assign abit = a_sr_q[WIDTH-1];
    assign bbit = b_sr_q[WIDTH-1];

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        cnt_d      = cnt_q;
        decided_d  = decided_q;
        lt_d       = lt_q;
        msb_diff_d = msb_diff_q;
        ul_d       = ul_q;
        sl_d       = sl_q;
        eq_d       = eq_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sr_d     = a;
                    b_sr_d     = b;
                    cnt_d      = CNT_MAX;
                    decided_d  = 1'b0;
                    lt_d       = 1'b0;
                    msb_diff_d = 1'b0;
                    state_d    = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                // Only the first differing bit matters; later bits are ignored.
                if (!decided_q && (abit != bbit)) begin
                    decided_d  = 1'b1;
                    lt_d       = bbit;
                    msb_diff_d = (cnt_q == CNT_MAX);
                end
                a_sr_d = {a_sr_q[WIDTH-2:0], 1'b0};
                b_sr_d = {b_sr_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_ONE;

                // Last bit: results use the flags as updated by this very bit.
                if (cnt_q == '0) begin
                    ul_d    = lt_d;
                    // A sign-bit difference flips the signed ordering.
                    sl_d    = lt_d ^ msb_diff_d;
                    eq_d    = ~decided_d;
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the operand shift registers are reset along with the control
    // state so an abandoned operation leaves no stale data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            cnt_q      <= '0;
            decided_q  <= 1'b0;
            lt_q       <= 1'b0;
            msb_diff_q <= 1'b0;
            ul_q       <= 1'b0;
            sl_q       <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            cnt_q      <= cnt_d;
            decided_q  <= decided_d;
            lt_q       <= lt_d;
            msb_diff_q <= msb_diff_d;
            ul_q       <= ul_d;
            sl_q       <= sl_d;
            eq_q       <= eq_d;
        end
    end

    // Status outputs are plain decodes of the state register.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign ul   = ul_q;
    assign sl   = sl_q;
    assign eq   = eq_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy && done));

    a_eq_not_less: assert property (@(posedge clk) disable iff (rst)
        eq |-> (!ul && !sl));

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

endmodule

// File: tb/tb_serial_comp_32.sv
// -----------------------------------------------------------------------------
// tb_serial_comp_32
//
// Scoreboard bench for serial_comp_32. Each accepted operation pushes the
// expected flags, computed with the language's own relational operators, and
// a monitor pops and compares them whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_comp_32;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             ul;
    logic             sl;
    logic             eq;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ul;
        logic             sl;
        logic             eq;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc      = 0;

    serial_comp_32 #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .ul    (ul),
        .sl    (sl),
        .eq    (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: sample away from the active edge and score every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            check("busy_with_done", {31'b0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ul", {31'b0, ul}, {31'b0, e.ul});
                check("sl", {31'b0, sl}, {31'b0, e.sl});
                check("eq", {31'b0, eq}, {31'b0, e.eq});
            end
        end
    end

    function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
        exp_t e;
        e.a  = aa;
        e.b  = bb;
        e.ul = (aa < bb);
        e.sl = ($signed(aa) < $signed(bb));
        e.eq = (aa == bb);
        return e;
    endfunction

    // Drive a start pulse across the next rising edge; push the expectation
    // only for starts that the DUT is supposed to accept.
    task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input bit push);
        start = 1'b1;
        a     = aa;
        b     = bb;
        if (push) sb.push_back(model(aa, bb));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Wait (bounded) for done at a falling edge; report busy cycles seen.
    task automatic wait_done(input int budget, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cycles++;
            n++;
            if (n >= budget) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        int bc;
        int t1;
        int t2;
        int d0;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ul",   {31'b0, ul},   32'd0);
        check("rst_sl",   {31'b0, sl},   32'd0);
        check("rst_eq",   {31'b0, eq},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic less-than with busy length
        issue(32'd5, 32'd7, 1'b1);
        wait_done(100, bc);
        check("busy_cycles", bc, 32'd32);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);

        // Sign-bit differences, equality, LSB-only difference
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done(100, bc);
        @(negedge clk);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done(100, bc);
        @(negedge clk);
        issue(32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_done(100, bc);
        @(negedge clk);
        check("eq_hold", {31'b0, eq}, 32'd1);
        issue(32'h1234_5678, 32'h1234_5679, 1'b1);
        wait_done(100, bc);
        @(negedge clk);

        // A few random operands
        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = (i == 0) ? ra ^ 32'h8000_0000 : $urandom;
            issue(ra, rb, 1'b1);
            wait_done(100, bc);
            @(negedge clk);
        end

        // start during RUN is ignored
        d0 = done_cnt;
        issue(32'd10, 32'd20, 1'b1);
        repeat (5) @(negedge clk);
        issue(32'd20, 32'd10, 1'b0);
        wait_done(100, bc);
        repeat (40) @(negedge clk);
        check("single_done", done_cnt - d0, 32'd1);

        // Back-to-back: start in the DONE cycle
        issue(32'h100, 32'h200, 1'b1);
        wait_done(100, bc);
        t1 = cyc;
        issue(32'd3, 32'd2, 1'b1);
        wait_done(100, bc);
        t2 = cyc;
        check("b2b_spacing", t2 - t1, 32'd33);
        @(negedge clk);

        // Reset mid-operation (E10), no done pulse afterwards
        d0 = done_cnt;
        issue(32'hAAAA_0000, 32'h0000_5555, 1'b1);   // edge E0 already passed
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_ul",   {31'b0, ul},   32'd0);
        check("midrst_sl",   {31'b0, sl},   32'd0);
        check("midrst_eq",   {31'b0, eq},   32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 32'd0);

        issue(32'h8000_0000, 32'h0000_0000, 1'b1);
        wait_done(100, bc);
        @(negedge clk);

        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
